gate_unit_arbiter: RTL and testbench

//  Shares one gate-level combinational logic unit (4-bit AND/OR/XOR/NAND

---
 rtl/gate_unit_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_gate_unit_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter: shares one combinational 4-op gate unit among NREQ requesters.
// Arbitrates, registers the winner's operands onto the unit, holds them for
// SETTLE clocks, then captures unit_y into result and pulses done.
// Optional build macro GATE_ARB_FIXED_PRIO_EN: fixed priority (lowest index
// wins) instead of the default round-robin.
module gate_unit_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 4,
    parameter int SETTLE = 3,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_op,
    output logic [WIDTH-1:0]      unit_a,
    output logic [WIDTH-1:0]      unit_b,
    output logic [1:0]            unit_op,
    input  logic [WIDTH-1:0]      unit_y,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [WIDTH-1:0]      result
);

    localparam int CW = $clog2(SETTLE + 1);

    // state  | meaning
    // IDLE   | nothing in flight; pending requests are arbitrated every edge
    // SETTLE | operands held on the unit while the gate delay settles

    typedef enum logic {S_IDLE = 1'b0, S_SETTLE = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [IDW-1:0]   owner, owner_nxt;
    logic [NREQ-1:0]  gnt_nxt;
    logic             busy_nxt, done_nxt;
    logic [IDW-1:0]   done_id_nxt;
    logic [WIDTH-1:0] result_nxt, unit_a_nxt, unit_b_nxt;
    logic [1:0]       unit_op_nxt;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [NREQ-1:0]  req_rot;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [1:0]       sel_op;

`ifndef GATE_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]   ptr, ptr_nxt;
`endif

    // Winner search: rotate so bit 0 of req_rot is the requester after the last winner
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef GATE_ARB_FIXED_PRIO_EN
        req_rot   = req;
`else
        req_rot   = NREQ'({req, req} >> (int'(ptr) + 1));
`endif
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
`ifdef GATE_ARB_FIXED_PRIO_EN
                win_idx   = IDW'(k);
`else
                win_idx   = IDW'((int'(ptr) + 1 + k) % NREQ);
`endif
            end
        end
    end

    // Operand mux for the current winner
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = req_op[i*2 +: 2];
            end
        end
    end

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            owner   <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            result  <= '0;
            unit_a  <= '0;
            unit_b  <= '0;
            unit_op <= '0;
`ifndef GATE_ARB_FIXED_PRIO_EN
            ptr     <= IDW'(NREQ - 1);
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            owner   <= owner_nxt;
            gnt     <= gnt_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            done_id <= done_id_nxt;
            result  <= result_nxt;
            unit_a  <= unit_a_nxt;
            unit_b  <= unit_b_nxt;
            unit_op <= unit_op_nxt;
`ifndef GATE_ARB_FIXED_PRIO_EN
            ptr     <= ptr_nxt;
`endif
        end
    end

    // Next-state: leave IDLE on any request, return when the settle count expires
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (win_found) state_nxt = S_SETTLE;
            S_SETTLE: if (cnt == CW'(1)) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        cnt_nxt     = cnt;
        owner_nxt   = owner;
        gnt_nxt     = gnt;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        done_id_nxt = done_id;
        result_nxt  = result;
        unit_a_nxt  = unit_a;
        unit_b_nxt  = unit_b;
        unit_op_nxt = unit_op;
`ifndef GATE_ARB_FIXED_PRIO_EN
        ptr_nxt     = ptr;
`endif
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    gnt_nxt     = NREQ'(1) << win_idx;
                    owner_nxt   = win_idx;
                    unit_a_nxt  = sel_a;
                    unit_b_nxt  = sel_b;
                    unit_op_nxt = sel_op;
                    busy_nxt    = 1'b1;
                    cnt_nxt     = CW'(SETTLE);
                end
            end
            S_SETTLE: begin
                if (cnt == CW'(1)) begin
                    result_nxt  = unit_y;
                    done_nxt    = 1'b1;
                    done_id_nxt = owner;
                    gnt_nxt     = '0;
                    busy_nxt    = 1'b0;
                    cnt_nxt     = '0;
`ifndef GATE_ARB_FIXED_PRIO_EN
                    ptr_nxt     = owner;
`endif
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench for gate_unit_arbiter: randomized requesters, a
// transaction-level arbitration model feeding a scoreboard, and a monitor.
module tb_gate_unit_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 4;
    localparam int SETTLE = 3;
    localparam int IDW    = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ*2-1:0]     req_op = '0;
    logic [WIDTH-1:0]      unit_a, unit_b, unit_y, result;
    logic [1:0]            unit_op;
    logic [NREQ-1:0]       gnt;
    logic                  busy, done;
    logic [IDW-1:0]        done_id;

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] gate_fn(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                                 logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Stub of the shared gate unit
    assign unit_y = gate_fn(unit_a, unit_b, unit_op);

    gate_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .unit_a(unit_a), .unit_b(unit_b), .unit_op(unit_op),
        .unit_y(unit_y), .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
        .result(result)
    );

    typedef struct {
        int               id;
        logic [WIDTH-1:0] y;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    // Requester models: 0 idle, 1 waiting, 2 granted
    int               r_state[NREQ];
    bit               r_drop[NREQ];
    logic [WIDTH-1:0] r_a[NREQ];
    logic [WIDTH-1:0] r_b[NREQ];
    logic [1:0]       r_op[NREQ];
    bit               auto_en = 0;

    // Arbitration model state
    int m_ptr = NREQ - 1;
    int m_next_arb = 0;
    int eg_owner = -1;
    int eg_from = 0;
    int eg_to = -1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (r_state[i] == 1) || (r_state[i] == 2 && !r_drop[i]);
            req_a[i*WIDTH +: WIDTH] = r_a[i];
            req_b[i*WIDTH +: WIDTH] = r_b[i];
            req_op[i*2 +: 2]        = r_op[i];
        end
    endtask

    // Predict what the next edge does: if the unit is free, pick the first
    // requester after the last winner and schedule its result SETTLE edges later.
    task automatic model_decide();
        int e;
        int win;
        e = edge_cnt + 1;
        win = -1;
        if (rst_n && e >= m_next_arb && req != '0) begin
            for (int k = 1; k <= NREQ && win < 0; k++) begin
`ifdef GATE_ARB_FIXED_PRIO_EN
                if (req[k-1]) win = k - 1;
`else
                if (req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
`endif
            end
            sb.push_back('{win, gate_fn(r_a[win], r_b[win], r_op[win]), e + SETTLE});
            eg_owner   = win;
            eg_from    = e;
            eg_to      = e + SETTLE - 1;
            m_next_arb = e + SETTLE + 1;
            m_ptr      = win;
            r_state[win] = 2;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst_n && done) begin
            r_state[done_id] = 0;
            r_drop[done_id]  = 0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (r_state[i] == 2) begin
                if (!r_drop[i] && $urandom_range(0, 3) == 0) r_drop[i] = 1;
                if ($urandom_range(0, 1) == 1) begin
                    r_a[i]  = WIDTH'($urandom);
                    r_b[i]  = WIDTH'($urandom);
                    r_op[i] = 2'($urandom);
                end
            end else if (r_state[i] == 0) begin
                r_a[i]  = WIDTH'($urandom);
                r_b[i]  = WIDTH'($urandom);
                r_op[i] = 2'($urandom);
                if (auto_en && $urandom_range(0, 2) == 0) r_state[i] = 1;
            end
        end
        drive();
        model_decide();
    endtask

    task automatic drain();
        int n;
        bit idle;
        n = 0;
        auto_en = 0;
        do begin
            step();
            n++;
            idle = (sb.size() == 0) && (gnt == '0);
            for (int i = 0; i < NREQ; i++) if (r_state[i] != 0) idle = 0;
        end while (!idle && n < 300);
        if (!idle) fail_now("drain");
    endtask

    // Monitor: grant/busy every cycle, one scoreboard entry per done pulse
    always @(negedge clk) begin
        int e;
        logic [NREQ-1:0] eg;
        exp_t x;
        if (rst_n) begin
            e  = edge_cnt;
            eg = '0;
            if (eg_owner >= 0 && e >= eg_from && e <= eg_to) eg[eg_owner] = 1'b1;
            check("gnt", 32'(gnt), 32'(eg));
            check("busy", 32'(busy), 32'(eg != '0));
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'(0));
                end else begin
                    x = sb.pop_front();
                    check("done_id", 32'(done_id), 32'(x.id));
                    check("result", 32'(result), 32'(x.y));
                    check("done_edge", 32'(e), 32'(x.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= e) begin
                x = sb.pop_front();
                fail_now("done_missing");
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < NREQ; i++) begin
            r_state[i] = 0;
            r_drop[i]  = 0;
            r_a[i]     = '0;
            r_b[i]     = '0;
            r_op[i]    = '0;
        end
        drive();

        // Asynchronous reset mid-cycle, no clock edge yet
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_done_id", 32'(done_id), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_unit", 32'({unit_a, unit_b, unit_op}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // All request at once: requester 0 first
        for (int i = 0; i < NREQ; i++) r_state[i] = 1;
        step();
        @(posedge clk);
        #1 check("first_gnt", 32'(gnt), 32'(4'b0001));
        drain();

        // Single XOR operation on requester 1
        r_a[1] = 4'hA; r_b[1] = 4'h6; r_op[1] = 2'b10; r_state[1] = 1;
        n = 0;
        do begin
            step();
            n++;
        end while (!done && n < 20);
        if (!done) fail_now("xor_done");
        else begin
            check("xor_result", 32'(result), 32'(4'hC));
            check("xor_id", 32'(done_id), 32'(1));
        end
        @(posedge clk);
        #1 check("gnt_after_done", 32'(gnt), 32'(0));
        drain();

        // All four held: back-to-back rotation
        for (int i = 0; i < NREQ; i++) r_state[i] = 1;
        drain();

        // Randomized traffic
        auto_en = 1;
        repeat (2000) step();

        // Reset in the middle of an operation
        auto_en = 0;
        if (sb.size() == 0) r_state[1] = 1;
        n = 0;
        do begin
            step();
            n++;
        end while (gnt == '0 && n < 40);
        if (gnt == '0) fail_now("busy_wait");
        #2 rst_n = 1'b0;
        #1;
        check("midrst_gnt", 32'(gnt), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_result", 32'(result), 32'(0));
        sb.delete();
        eg_owner = -1;
        m_next_arb = 0;
        m_ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            r_state[i] = 0;
            r_drop[i]  = 0;
        end
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r_state[2] = 1;
        step();
        @(posedge clk);
        #1 check("post_rst_gnt", 32'(gnt), 32'(4'b0100));
        drain();

        auto_en = 1;
        repeat (1000) step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
